// File: rtl/sad_window_bank.sv
// sad_window_bank: reference window bank plus frame bank for the SAD datapath.
// The frame bank fills one column per beat, then slides one column per beat
// along a FRAME_COLS-wide search row. It pulses RowEnd at the last position
// and inserts a one-cycle turnaround bubble before the next row fill.
// All state changes on the falling edge of Clk.
// Optional build macro SAD_BANK_CLEAR_EN adds a synchronous Clear input.
// Clear zeroes both banks and returns the sequencer to FILL.
module sad_window_bank #(
  parameter int DATA_W     = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int FRAME_COLS = 16,
  localparam int ELEMS     = ROWS * COLS,
  localparam int CP_W      = (FRAME_COLS > 1) ? $clog2(FRAME_COLS) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
`ifdef SAD_BANK_CLEAR_EN
  input  logic                      Clear,
`endif
  input  logic                      CmdValid,
  output logic                      CmdReady,
  input  logic [1:0]                Cmd,
  input  logic [ELEMS*DATA_W-1:0]   WrData,
  input  logic [ROWS*DATA_W-1:0]    ColData,
  output logic [ELEMS*DATA_W-1:0]   WinData,
  output logic [ELEMS*DATA_W-1:0]   FrameData,
  output logic                      WinValid,
  output logic                      FrameValid,
  output logic                      SadValid,
  output logic [CP_W-1:0]           ColPos,
  output logic                      RowEnd
);

  localparam int FC_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [FC_W-1:0] FILL_LAST = FC_W'(COLS - 1);
  localparam logic [CP_W-1:0] POS_LAST  = CP_W'(FRAME_COLS - COLS);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_EOR   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WIN   = 2'b01,
    CMD_FRAME = 2'b10,
    CMD_COL   = 2'b11
  } cmd_t;

  state_t                    state_q, state_d;
  logic [FC_W-1:0]           fill_q, fill_d;
  logic [CP_W-1:0]           pos_q, pos_d, pos_inc;
  logic                      win_valid_q, win_valid_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      row_end_q, row_end_d;
  logic [ELEMS*DATA_W-1:0]   win_q, frame_q, frame_shift;
  logic                      clr;
  logic                      accept;
  cmd_t                      cmd;

`ifdef SAD_BANK_CLEAR_EN
  assign clr = Clear;
`else
  assign clr = 1'b0;
`endif

  // The turnaround bubble is the only cycle in which commands are refused.
  assign CmdReady = (state_q != ST_EOR);
  assign accept   = CmdValid & CmdReady;
  assign cmd      = cmd_t'(Cmd);
  assign pos_inc  = pos_q + 1'b1;

  // Frame bank after one column beat: every column moves left, ColData enters on the right.
  always_comb begin
    frame_shift = frame_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c < COLS - 1)
          frame_shift[(r*COLS+c)*DATA_W +: DATA_W] = frame_q[(r*COLS+c+1)*DATA_W +: DATA_W];
        else
          frame_shift[(r*COLS+c)*DATA_W +: DATA_W] = ColData[r*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and flag logic for the fill / slide / end-of-row sequencer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    fill_d        = fill_q;
    pos_d         = pos_q;
    win_valid_d   = win_valid_q;
    frame_valid_d = frame_valid_q;
    row_end_d     = 1'b0;

    if (clr) begin
      state_d       = ST_FILL;
      fill_d        = '0;
      pos_d         = '0;
      win_valid_d   = 1'b0;
      frame_valid_d = 1'b0;
    end else if (state_q == ST_EOR) begin
      // Bubble cycle: retire the row and start filling the next one.
      state_d       = ST_FILL;
      frame_valid_d = 1'b0;
      pos_d         = '0;
      fill_d        = '0;
    end else if (accept) begin
      case (cmd)
        CMD_WIN: win_valid_d = 1'b1;
        CMD_FRAME: begin
          frame_valid_d = 1'b1;
          pos_d         = '0;
          fill_d        = '0;
          state_d       = ST_SLIDE;
        end
        CMD_COL: begin
          if (state_q == ST_FILL) begin
            if (fill_q == FILL_LAST) begin
              frame_valid_d = 1'b1;
              fill_d        = '0;
              pos_d         = '0;
              // A row exactly one block wide ends on the very beat that fills it.
              if (FRAME_COLS == COLS) begin
                row_end_d = 1'b1;
                state_d   = ST_EOR;
              end else begin
                state_d   = ST_SLIDE;
              end
            end else begin
              fill_d = fill_q + 1'b1;
            end
          end else begin
            pos_d = pos_inc;
            if (pos_inc == POS_LAST) begin
              row_end_d = 1'b1;
              state_d   = ST_EOR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and status flags.
  always_ff @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_FILL;
      fill_q        <= '0;
      pos_q         <= '0;
      win_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      row_end_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      fill_q        <= fill_d;
      pos_q         <= pos_d;
      win_valid_q   <= win_valid_d;
      frame_valid_q <= frame_valid_d;
      row_end_q     <= row_end_d;
    end
  end

  // Window and frame bank storage.
  always_ff @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: the banks are reset because zero contents after reset are part
      // of the block's visible behaviour, not merely an initial value.
      win_q   <= '0;
      frame_q <= '0;
    end else if (clr) begin
      win_q   <= '0;
      frame_q <= '0;
    end else if (accept) begin
      case (cmd)
        CMD_WIN:   win_q   <= WrData;
        CMD_FRAME: frame_q <= WrData;
        CMD_COL:   frame_q <= frame_shift;
        default: ;
      endcase
    end
  end

  assign WinData    = win_q;
  assign FrameData  = frame_q;
  assign WinValid   = win_valid_q;
  assign FrameValid = frame_valid_q;
  assign SadValid   = win_valid_q & frame_valid_q;
  assign ColPos     = pos_q;
  assign RowEnd     = row_end_q;

endmodule
